// File: rtl/csr_pkg.sv
// Shared types and helpers for the CSR encoder/decoder pair: FSM states,
// default geometry, and raster position arithmetic.
package csr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } csr_state_e;

    localparam int DEF_IMAGE_SIZE   = 28;
    localparam int DEF_WORD_LENGTH  = 8;
    localparam int DEF_COL_LENGTH   = 8;
    localparam int DEF_DWORD_LENGTH = 16;

    function automatic int unsigned frame_pixels(input int unsigned size);
        return size * size;
    endfunction

    // Raster position of (row, col); must stay identical to the encoder's view.
    function automatic logic [DEF_DWORD_LENGTH-1:0] pos_from_rc(
        input logic [DEF_DWORD_LENGTH-1:0] row,
        input logic [DEF_DWORD_LENGTH-1:0] col,
        input logic [DEF_DWORD_LENGTH-1:0] size
    );
        return row * size + col;
    endfunction

endpackage

// File: rtl/csr_raster_counter.sv
// Raster position counter for one dense frame: clears on frame start,
// steps once per emitted pixel, and flags the last and terminal positions.
module csr_raster_counter #(
    parameter int pos_width = 16,
    parameter logic [pos_width-1:0] n2 = pos_width'(784)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 adv,
    output logic [pos_width-1:0] pos,
    output logic                 is_last,
    output logic                 terminal
);

    localparam logic [pos_width-1:0] POS_ONE = pos_width'(1);

    logic [pos_width-1:0] pos_q, pos_d;

    always_comb begin
        pos_d = pos_q;
        if (clear) begin
            pos_d = '0;
        end else if (adv) begin
            pos_d = pos_q + POS_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q <= '0;
        end else begin
            pos_q <= pos_d;
        end
    end

    assign pos      = pos_q;
    assign is_last  = (pos_q == n2 - POS_ONE);
    // Once pos reaches n2 the frame is fully emitted and the counter parks.
    assign terminal = (pos_q == n2);

endmodule

// File: rtl/csr_decoder.sv
// Expands a raster-ordered stream of nonzero (value, col, row) entries into a
// dense image_size x image_size pixel stream. Optional CSR_DEC_BOUND_CHECK_EN
// drops out-of-order / out-of-range entries and raises a sticky err.
module csr_decoder
    import csr_pkg::*;
#(
    parameter int col_length         = DEF_COL_LENGTH,
    parameter int word_length        = DEF_WORD_LENGTH,
    parameter int double_word_length = DEF_DWORD_LENGTH,
    parameter int image_size         = DEF_IMAGE_SIZE
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [double_word_length-1:0] nnz,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [word_length-1:0]        in_value,
    input  logic [col_length-1:0]         in_col,
    input  logic [col_length-1:0]         in_row,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [word_length-1:0]        data_out,
    output logic                          out_last,
    output logic                          done,
    output logic                          err,
    output logic [1:0]                    state_dbg
);

    // Handshakes: an entry transfers in a cycle where in_valid && in_ready;
    // a pixel transfers on a rising edge where out_valid && out_ready, and the
    // pixel registers hold steady while out_valid && !out_ready.

    localparam logic [double_word_length-1:0] N2 =
        double_word_length'(frame_pixels(image_size));
    localparam logic [double_word_length-1:0] DW_ONE = double_word_length'(1);
    localparam logic [col_length-1:0] IMG_COL = col_length'(image_size);

    csr_state_e                    state_q, state_d;
    logic [double_word_length-1:0] remaining_q, remaining_d;
    logic [word_length-1:0]        data_q, data_d;
    logic                          out_valid_q, out_valid_d;
    logic                          out_last_q, out_last_d;
    logic                          err_q, err_d;

    logic [double_word_length-1:0] pos, head_pos;
    logic is_last, terminal, cnt_clear, cnt_adv;
    logic col_ok, match, out_free, bad_entry;

    csr_raster_counter #(
        .pos_width (double_word_length),
        .n2        (N2)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear),
        .adv      (cnt_adv),
        .pos      (pos),
        .is_last  (is_last),
        .terminal (terminal)
    );

    assign head_pos = double_word_length'(pos_from_rc(DEF_DWORD_LENGTH'(in_row),
                                                      DEF_DWORD_LENGTH'(in_col),
                                                      DEF_DWORD_LENGTH'(image_size)));
    assign col_ok   = (in_col < IMG_COL);
    // An out-of-range column never matches, so it cannot alias a later row.
    assign match    = in_valid && (remaining_q != '0) && col_ok && (head_pos == pos);
    assign out_free = !out_valid_q || out_ready;

`ifdef CSR_DEC_BOUND_CHECK_EN
    assign bad_entry = in_valid && (remaining_q != '0) && ((head_pos < pos) || !col_ok);
`else
    assign bad_entry = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        data_d      = data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        err_d       = err_q;
        in_ready    = 1'b0;
        cnt_clear   = 1'b0;
        cnt_adv     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    remaining_d = nnz;
                    err_d       = 1'b0;
                    cnt_clear   = 1'b1;
                end
            end

            RUN: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
                if (!terminal) begin
                    if (bad_entry) begin
                        in_ready    = 1'b1;
                        remaining_d = remaining_q - DW_ONE;
                        err_d       = 1'b1;
                    end else if (out_free && ((remaining_q == '0) || in_valid)) begin
                        cnt_adv     = 1'b1;
                        out_valid_d = 1'b1;
                        out_last_d  = is_last;
                        data_d      = match ? in_value : '0;
                        if (match) begin
                            in_ready    = 1'b1;
                            remaining_d = remaining_q - DW_ONE;
                        end
                    end
                end else if (!out_valid_q) begin
                    state_d = DONE;
`ifdef CSR_DEC_BOUND_CHECK_EN
                    // Leftover entries stay upstream; only the flag records them.
                    if (remaining_q != '0) begin
                        err_d = 1'b1;
                    end
`endif
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            data_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            data_q      <= data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign data_out  = data_q;
    assign out_last  = out_last_q;
    assign done      = (state_q == DONE);
    assign err       = err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_csr_decoder.sv
// Self-checking bench for csr_decoder at image_size=4: scoreboard of dense
// pixels built from a small raster model, driven entry/ready stimulus.
module tb_csr_decoder;
    import csr_pkg::*;

    localparam int IMG  = 4;
    localparam int NPIX = IMG * IMG;

    logic        clk, rst, start;
    logic [15:0] nnz;
    logic        in_valid, in_ready;
    logic [7:0]  in_value, in_col, in_row;
    logic        out_valid, out_ready;
    logic [7:0]  data_out;
    logic        out_last, done, err;
    logic [1:0]  state_dbg;

    csr_decoder #(
        .col_length         (8),
        .word_length        (8),
        .double_word_length (16),
        .image_size         (IMG)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .nnz       (nnz),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .in_col    (in_col),
        .in_row    (in_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .out_last  (out_last),
        .done      (done),
        .err       (err),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // scoreboard state
    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // entry table and driver state
    logic [7:0] ent_val[8];
    logic [7:0] ent_col[8];
    logic [7:0] ent_row[8];
    int  n_ent = 0;
    int  ent_idx = 0, gap = 0, gap_left = 0;
    bit  feed_en = 0, took = 0, ready_mode = 0;
    logic [1:0] rcyc = 2'd0;
    logic [3:0] ready_pat = 4'b1001;

    int  cyc = 0, pix_cnt = 0, consumed = 0, ir_cnt = 0, done_cnt = 0;
    int  last_cyc = -100, done_cyc = 0;
    bit  hold_pending = 0;
    logic [7:0] hold_data;
    logic       hold_last;

    task automatic set_ent(input int i, input int v, input int c, input int r);
        ent_val[i] = v[7:0];
        ent_col[i] = c[7:0];
        ent_row[i] = r[7:0];
    endtask

    // upstream entry driver
    always @(posedge clk) begin
        #1;
        if (!feed_en) begin
            in_valid = 1'b0;
            took     = 0;
        end else begin
            if (took) begin
                took     = 0;
                ent_idx  = ent_idx + 1;
                in_valid = 1'b0;
                gap_left = gap;
            end
            if (!in_valid && ent_idx < n_ent) begin
                if (gap_left > 0) begin
                    gap_left = gap_left - 1;
                end else begin
                    in_valid = 1'b1;
                    in_value = ent_val[ent_idx];
                    in_col   = ent_col[ent_idx];
                    in_row   = ent_row[ent_idx];
                end
            end
        end
    end

    // downstream ready driver
    always @(posedge clk) begin
        #1;
        if (ready_mode) begin
            out_ready = ready_pat[rcyc];
            rcyc      = rcyc + 2'd1;
        end else begin
            out_ready = 1'b1;
        end
    end

    // monitor: pops the scoreboard on each accepted pixel
    always @(negedge clk) begin
        logic [7:0] e;
        cyc++;
        if (rst) begin
            hold_pending = 0;
        end else begin
            if (in_valid && in_ready) begin
                took = 1;
                consumed++;
            end
            if (in_ready) ir_cnt++;
            if (hold_pending) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", data_out, hold_data);
                check("hold_last", out_last, hold_last);
            end
            hold_pending = out_valid && !out_ready;
            hold_data    = data_out;
            hold_last    = out_last;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_pixel", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pixel", data_out, e);
                    check("last_flag", out_last, (pix_cnt == NPIX - 1));
                end
                if (out_last) last_cyc = cyc;
                pix_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // golden raster model: fills exp_q, returns expected consumption and err
    task automatic build_golden(output int exp_cons, output bit exp_err);
        int h, hp;
        h = 0;
        exp_cons = 0;
        exp_err  = 0;
        exp_q.delete();
        for (int p = 0; p < NPIX; p++) begin
`ifdef CSR_DEC_BOUND_CHECK_EN
            while (h < n_ent && ((int'(ent_row[h]) * IMG + int'(ent_col[h]) < p) ||
                                 int'(ent_col[h]) >= IMG)) begin
                h++;
                exp_cons++;
                exp_err = 1;
            end
`endif
            hp = (h < n_ent) ? int'(ent_row[h]) * IMG + int'(ent_col[h]) : -1;
            if (h < n_ent && int'(ent_col[h]) < IMG && hp == p) begin
                exp_q.push_back(ent_val[h]);
                h++;
                exp_cons++;
            end else begin
                exp_q.push_back(8'd0);
            end
        end
`ifdef CSR_DEC_BOUND_CHECK_EN
        if (h < n_ent) exp_err = 1;
`endif
    endtask

    task automatic run_frame(input int gap_i, input bit rmode, input bit lat_chk,
                             input bit poke, input int abort_at);
        int  exp_cons, waited;
        bit  exp_err;
        build_golden(exp_cons, exp_err);
        @(posedge clk);
        #1;
        pix_cnt = 0; consumed = 0; ir_cnt = 0; done_cnt = 0;
        last_cyc = -100; done_cyc = 0;
        ent_idx = 0; gap_left = 0; took = 0; gap = gap_i;
        ready_mode = rmode; rcyc = 2'd0;
        nnz = 16'(n_ent);
        start = 1'b1;
        feed_en = 1;
        @(posedge clk);
        #1 start = 1'b0;
        if (lat_chk) begin
            @(negedge clk); #1;
            check("lat_early", out_valid, 0);
            @(negedge clk); #1;
            check("lat_first", out_valid, 1);
        end
        if (poke) begin
            repeat (4) @(posedge clk);
            #1 start = 1'b1;
            nnz = 16'd7;
            @(posedge clk);
            #1 start = 1'b0;
        end
        if (abort_at > 0) begin
            waited = 0;
            while (pix_cnt < abort_at && waited < 200) begin
                @(negedge clk); #1;
                waited++;
            end
            check("abort_reach", pix_cnt >= abort_at, 1);
            #2 rst = 1'b1;
            #1;
            check("arst_valid", out_valid, 0);
            check("arst_done", done, 0);
            check("arst_err", err, 0);
            check("arst_last", out_last, 0);
            check("arst_state", state_dbg, IDLE);
            feed_en = 0; ready_mode = 0;
            in_valid = 1'b0;
            exp_q.delete();
            @(posedge clk);
            @(posedge clk);
            #1 rst = 1'b0;
            return;
        end
        waited = 0;
        while (done_cnt == 0 && waited < 400) begin
            @(negedge clk); #1;
            waited++;
        end
        check("done_seen", done_cnt != 0, 1);
        check("done_after_last", done_cyc - last_cyc, 2);
        check("err_at_done", err, exp_err);
        @(negedge clk); #1;
        check("done_pulse", done, 0);
        check("done_count", done_cnt, 1);
        check("state_idle", state_dbg, IDLE);
        check("pixel_count", pix_cnt, NPIX);
        check("queue_empty", exp_q.size(), 0);
        check("consumed", consumed, exp_cons);
        check("err_sticky", err, exp_err);
        if (n_ent == 0) check("no_in_ready", ir_cnt, 0);
        feed_en = 0;
        ready_mode = 0;
    endtask

    task automatic load_basic();
        n_ent = 3;
        set_ent(0, 5, 1, 0);
        set_ent(1, 7, 3, 1);
        set_ent(2, 9, 0, 3);
    endtask

    initial begin
        int p, k;
        rst = 1'b1; start = 1'b0; nnz = '0;
        in_valid = 1'b0; in_value = '0; in_col = '0; in_row = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_data", data_out, 0);
        check("rst_last", out_last, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_state", state_dbg, IDLE);
        @(posedge clk);
        #1 rst = 1'b0;

        // basic frame with first-pixel latency
        load_basic();
        run_frame(0, 0, 1, 0, 0);

        // empty frame
        n_ent = 0;
        run_frame(0, 0, 1, 0, 0);

        // out-of-order second entry
        n_ent = 2;
        set_ent(0, 3, 2, 0);
        set_ent(1, 4, 1, 0);
        run_frame(0, 0, 0, 0, 0);

        // back-pressure pattern plus an ignored mid-frame start
        load_basic();
        run_frame(0, 1, 0, 1, 0);

        // gaps between entries
        load_basic();
        run_frame(3, 0, 0, 0, 0);

        // random legal frames
        for (int it = 0; it < 3; it++) begin
            p = -1;
            k = 0;
            for (int i = 0; i < 6; i++) begin
                p = p + int'($urandom_range(1, 4));
                if (p < NPIX) begin
                    set_ent(k, int'($urandom_range(1, 255)), p % IMG, p / IMG);
                    k++;
                end
            end
            n_ent = k;
            run_frame(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 0, 0, 0);
        end

        // reset mid-frame, then a fresh frame
        load_basic();
        run_frame(0, 0, 0, 0, 7);
        n_ent = 1;
        set_ent(0, 1, 0, 0);
        run_frame(0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
